// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR stream generator.
// Holds the FSM state enum, default tap masks and a counter-width helper.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } lfsr_state_t;

    localparam logic [3:0]  TAPS_W4  = 4'h3;
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;

    function automatic logic [63:0] def_taps(input int wid);
        logic [63:0] t;
        t = 64'(TAPS_W8);
        if (wid == 4)  t = 64'(TAPS_W4);
        if (wid == 16) t = 64'(TAPS_W16);
        return t;
    endfunction

    function automatic int cnt_w(input int warmup);
        int w;
        w = $clog2(warmup + 1);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register with load / shift / hold control.
// Load has priority over shift; the LSB is the serial output.
module lfsr_core #(
    parameter int             WID  = 8,
    parameter logic [WID-1:0] TAPS = WID'(8'hB8)
) (
    input  logic           clk,
    input  logic           rest,
    input  logic           i_load,
    input  logic [WID-1:0] i_load_val,
    input  logic           i_shift,
    output logic [WID-1:0] o_lfsr
);

    logic [WID-1:0] r_lfsr;
    logic           w_fb;

    assign w_fb   = ^(r_lfsr & TAPS);
    assign o_lfsr = r_lfsr;

    // state register: load beats shift, otherwise hold
    always_ff @(posedge clk) begin
        if (!rest) begin
            r_lfsr <= '0;
        end else if (i_load) begin
            r_lfsr <= i_load_val;
        end else if (i_shift) begin
            r_lfsr <= {w_fb, r_lfsr[WID-1:1]};
        end
    end

endmodule

// File: rtl/lfsr_stream_gen.sv
// LFSR bit-stream generator: seed reload, warm-up discard, valid/ready output.
// Optional zero-seed guard enabled by defining LFSR_ZERO_GUARD_EN.
module lfsr_stream_gen
    import lfsr_pkg::*;
#(
    parameter int             WID      = 8,
    parameter logic [WID-1:0] TAPS     = WID'(def_taps(WID)),
    parameter int             WARMUP   = 8,
    parameter logic [WID-1:0] DEF_SEED = WID'(1)
) (
    input  logic           clk,
    input  logic           rest,
    input  logic           seed_vld,
    input  logic [WID-1:0] seed,
    input  logic           out_ready,
    output logic           out,
    output logic           out_valid,
    output logic           busy,
    output logic           zero_seed
);

    localparam int             CW     = cnt_w(WARMUP);
    localparam int             LAST   = (WARMUP > 0) ? WARMUP - 1 : 0;
    localparam logic [CW-1:0]  LAST_C = CW'(LAST);
    localparam lfsr_state_t    LOAD_S = (WARMUP == 0) ? RUN : WARM;

`ifdef LFSR_ZERO_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    lfsr_state_t    r_state;
    lfsr_state_t    w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic           w_shift;
    logic           w_hs;
    logic           w_seed_zero;
    logic           w_lock;
    logic           w_load;
    logic [WID-1:0] w_load_val;
    logic [WID-1:0] w_lfsr;

    assign w_hs        = (r_state == RUN) && out_ready;
    assign w_seed_zero = GUARD && seed_vld && (seed == '0);
    assign w_lock      = GUARD && w_shift && (w_lfsr == '0);
    assign w_load      = seed_vld || w_lock;
    assign w_load_val  = (w_seed_zero || (w_lock && !seed_vld))
                         ? DEF_SEED : seed;

    lfsr_core #(
        .WID  (WID),
        .TAPS (TAPS)
    ) u_core (
        .clk        (clk),
        .rest       (rest),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_shift    (w_shift),
        .o_lfsr     (w_lfsr)
    );

    // FSM state and warm-up counter registers
    always_ff @(posedge clk) begin
        if (!rest) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // next state, shift enable and counter; a seed load overrides all
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift     = 1'b0;
        unique case (r_state)
            IDLE: begin
            end
            WARM: begin
                w_shift   = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST_C) w_state_nxt = RUN;
            end
            RUN: begin
                w_shift = w_hs;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (seed_vld) begin
            w_state_nxt = LOAD_S;
            w_cnt_nxt   = '0;
        end
    end

`ifdef LFSR_ZERO_GUARD_EN
    logic r_zero;

    // sticky flag: a zero seed was replaced by DEF_SEED
    always_ff @(posedge clk) begin
        if (!rest) begin
            r_zero <= 1'b0;
        end else if (w_seed_zero) begin
            r_zero <= 1'b1;
        end
    end

    assign zero_seed = r_zero;
`else
    assign zero_seed = 1'b0;
`endif

    assign out       = w_lfsr[0];
    assign out_valid = (r_state == RUN);
    assign busy      = (r_state == WARM);

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Bench for lfsr_stream_gen: WID=4, TAPS=4'h3, two instances (WARMUP 0 and 8).
// Vector table for the reference stream, scoreboard for every handshaked bit.
module tb_lfsr_stream_gen;

    logic       clk = 1'b0;
    logic       rest;
    logic       seed_vld;
    logic [3:0] seed;
    logic       out_ready;

    logic o0, v0, b0, z0;
    logic o8, v8, b8, z8;

    int n_vec = 0;
    int n_err = 0;

    logic q0[$];
    logic q8[$];

    always #5 clk = ~clk;

    lfsr_stream_gen #(
        .WID(4), .TAPS(4'h3), .WARMUP(0), .DEF_SEED(4'h1)
    ) u_dut0 (
        .clk(clk), .rest(rest), .seed_vld(seed_vld), .seed(seed),
        .out_ready(out_ready), .out(o0), .out_valid(v0),
        .busy(b0), .zero_seed(z0)
    );

    lfsr_stream_gen #(
        .WID(4), .TAPS(4'h3), .WARMUP(8), .DEF_SEED(4'h1)
    ) u_dut8 (
        .clk(clk), .rest(rest), .seed_vld(seed_vld), .seed(seed),
        .out_ready(out_ready), .out(o8), .out_valid(v8),
        .busy(b8), .zero_seed(z8)
    );

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expected bit streams after a seed load (spec feedback formula)
    task automatic reload_q(input logic [3:0] s0);
        logic [3:0] s;
        s = s0;
        q0.delete();
        q8.delete();
`ifdef LFSR_ZERO_GUARD_EN
        if (s == 4'h0) s = 4'h1;
`endif
        for (int i = 0; i < 70; i++) begin
            if (i < 60) q0.push_back(s[0]);
            if (i >= 8) q8.push_back(s[0]);
            s = {^(s & 4'h3), s[3:1]};
        end
    endtask

    task automatic load(input logic [3:0] s);
        seed_vld = 1'b1;
        seed     = s;
        tick();
        seed_vld = 1'b0;
        reload_q(s);
    endtask

    // scoreboard: pop and compare on every handshake
    always @(negedge clk) begin
        logic e;
        if (rest && out_ready && v0) begin
            if (q0.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL q0_empty: got handshake expected none");
            end else begin
                e = q0.pop_front();
                chk("stream0", 8'(o0), 8'(e));
            end
        end
        if (rest && out_ready && v8) begin
            if (q8.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL q8_empty: got handshake expected none");
            end else begin
                e = q8.pop_front();
                chk("stream8", 8'(o8), 8'(e));
            end
        end
    end

    typedef struct {
        logic       sv;
        logic [3:0] seed;
        logic       rdy;
        logic       o0;
        logic       v0;
        logic       o8;
        logic       v8;
        logic       b8;
    } vec_t;

    vec_t tbl[20];
    logic seq[15] = '{0,0,0,1,0,0,1,1,0,1,0,1,1,1,1};
    logic exp4[4] = '{0,0,0,1};

    initial begin
        logic p0, p8;

        for (int k = 0; k < 20; k++) begin
            tbl[k].sv   = (k == 0);
            tbl[k].seed = 4'h8;
            tbl[k].rdy  = 1'b1;
            tbl[k].o0   = seq[k % 15];
            tbl[k].v0   = 1'b1;
            tbl[k].o8   = seq[k % 15];
            tbl[k].v8   = (k >= 8);
            tbl[k].b8   = (k < 8);
        end

        rest = 1'b0; seed_vld = 1'b0; seed = 4'h0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid0", 8'(v0), 8'h0);
        chk("rst_valid8", 8'(v8), 8'h0);
        chk("rst_busy8",  8'(b8), 8'h0);
        chk("rst_out0",   8'(o0), 8'h0);
        chk("rst_zero0",  8'(z0), 8'h0);

        rest = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        chk("idle_valid0", 8'(v0), 8'h0);
        chk("idle_busy8",  8'(b8), 8'h0);

        // tests 1 and 2: stream from seed 8, with and without warm-up
        for (int k = 0; k < 20; k++) begin
            seed_vld  = tbl[k].sv;
            seed      = tbl[k].seed;
            out_ready = tbl[k].rdy;
            tick();
            if (tbl[k].sv) reload_q(tbl[k].seed);
            seed_vld = 1'b0;
            chk($sformatf("t_o0[%0d]", k), 8'(o0), 8'(tbl[k].o0));
            chk($sformatf("t_v0[%0d]", k), 8'(v0), 8'(tbl[k].v0));
            chk($sformatf("t_o8[%0d]", k), 8'(o8), 8'(tbl[k].o8));
            chk($sformatf("t_v8[%0d]", k), 8'(v8), 8'(tbl[k].v8));
            chk($sformatf("t_b8[%0d]", k), 8'(b8), 8'(tbl[k].b8));
        end

        // test 3: backpressure holds the current bit
        p0 = o0;
        p8 = o8;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_o0", 8'(o0), 8'(p0));
            chk("stall_v0", 8'(v0), 8'h1);
            chk("stall_o8", 8'(o8), 8'(p8));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        // test 4: reload during a RUN handshake restarts the sequence
        load(4'h8);
        chk("rl_o0[0]", 8'(o0), 8'(exp4[0]));
        chk("rl_v8",    8'(v8), 8'h0);
        chk("rl_b8",    8'(b8), 8'h1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("rl_o0[%0d]", i), 8'(o0), 8'(exp4[i]));
        end

        // test 5: zero seed
        load(4'h0);
        chk("z_v0", 8'(v0), 8'h1);
`ifdef LFSR_ZERO_GUARD_EN
        chk("z_flag0", 8'(z0), 8'h1);
        chk("z_o0",    8'(o0), 8'h1);
`else
        chk("z_flag0", 8'(z0), 8'h0);
        chk("z_o0",    8'(o0), 8'h0);
`endif
        for (int i = 0; i < 10; i++) tick();
        chk("z_v8", 8'(v8), 8'h1);

        // test 6a: reset during WARM
        load(4'h8);
        tick();
        tick();
        chk("w_busy8", 8'(b8), 8'h1);
        rest = 1'b0;
        tick();
        rest = 1'b1;
        q0.delete();
        q8.delete();
        chk("rw_v0", 8'(v0), 8'h0);
        chk("rw_v8", 8'(v8), 8'h0);
        chk("rw_b8", 8'(b8), 8'h0);
        chk("rw_z0", 8'(z0), 8'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rw_idle_v0", 8'(v0), 8'h0);
            chk("rw_idle_o0", 8'(o0), 8'h0);
            chk("rw_idle_b8", 8'(b8), 8'h0);
        end

        // test 6b: reset during RUN dominates a seed load
        load(4'h8);
        for (int i = 0; i < 10; i++) tick();
        chk("r_v8", 8'(v8), 8'h1);
        rest = 1'b0;
        seed_vld = 1'b1;
        seed = 4'h5;
        tick();
        rest = 1'b1;
        seed_vld = 1'b0;
        q0.delete();
        q8.delete();
        chk("rr_v0", 8'(v0), 8'h0);
        chk("rr_v8", 8'(v8), 8'h0);
        chk("rr_b8", 8'(b8), 8'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rr_idle_v0", 8'(v0), 8'h0);
            chk("rr_idle_b8", 8'(b8), 8'h0);
            chk("rr_idle_o8", 8'(o8), 8'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
